commit_trace_unit: RTL and testbench

- Commit-side writer of the retirement trace stream. It sits at the end of the WB stage of the pipelined CPU and packs every retiring instruction into a trace record: its register write, memory write or halt.
- Records are buffered in a small FIFO and emitted over a valid/ready stream, to be consumed by the bench-side checker or a trace port.
- It applies back-pressure to the pipeline through stall_req and drains cleanly after HLT retires.

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 51 +++++
 rtl/commit_trace_unit.sv | 125 ++++++++++++
 tb/tb_commit_trace_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the retirement trace stream: record kinds, the packed
// trace record and the commit-side FSM states.
package trace_pkg;

  typedef enum logic [1:0] {
    RETIRE = 2'd0,
    REG    = 2'd1,
    MEM    = 2'd2,
    HLT    = 2'd3
  } trace_kind_t;

  typedef struct packed {
    logic [15:0] seq;
    trace_kind_t kind;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] data;
  } trace_rec_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records. The caller decides acceptance; push and
// pop are taken as-is. The head entry is read combinationally.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  trace_rec_t               wr_rec,
  output trace_rec_t               rd_rec,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_rec_t       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage needs no reset: entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_rec = mem[rd_ptr];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

endmodule

// File: rtl/commit_trace_unit.sv
// Commit-side trace writer: packs each retirement into a record, buffers it
// and streams it out. Build option TRACE_FILTER_NOP_EN drops RETIRE records.
module commit_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ret_valid,
  input  logic [15:0] ret_pc,
  input  logic        ret_regwrite,
  input  logic [3:0]  ret_rd,
  input  logic [15:0] ret_wdata,
  input  logic        ret_memwrite,
  input  logic [15:0] ret_maddr,
  input  logic [15:0] ret_mdata,
  input  logic        ret_hlt,
  output logic        stall_req,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [15:0] trace_seq,
  output logic [1:0]  trace_kind,
  output logic [15:0] trace_pc,
  output logic [15:0] trace_addr,
  output logic [15:0] trace_data,
  output logic        overflow,
  output logic        drained
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Stream handshake: a record transfers on a posedge where trace_valid and
  // trace_ready are both high; the head stays stable until then.

  trace_state_t   state;
  logic [15:0]    seq;
  logic           hlt_queued;
  trace_rec_t     rec;
  trace_rec_t     head;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           want;
  logic           push;
  logic           pop;
  logic           drop;

  always_comb begin
    rec      = '0;
    rec.seq  = seq;
    rec.pc   = ret_pc;
    rec.kind = RETIRE;
    if (ret_hlt) begin
      rec.kind = HLT;
    end else if (ret_memwrite) begin
      rec.kind = MEM;
      rec.addr = ret_maddr;
      rec.data = ret_mdata;
    end else if (ret_regwrite) begin
      rec.kind = REG;
      rec.addr = {12'b0, ret_rd};
      rec.data = ret_wdata;
    end
  end

`ifdef TRACE_FILTER_NOP_EN
  assign want = ret_valid && (state == RUN) && (rec.kind != RETIRE);
`else
  assign want = ret_valid && (state == RUN);
`endif

  assign trace_valid = !empty && (state != DONE);
  assign pop         = trace_valid && trace_ready;
  assign push        = want && (!full || pop);
  assign drop        = want && full && !pop;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wr_rec (rec),
    .rd_rec (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      seq        <= '0;
      overflow   <= 1'b0;
      hlt_queued <= 1'b0;
    end else begin
      if (push) seq <= seq + 16'd1;
      if (drop) overflow <= 1'b1;
      case (state)
        RUN: begin
          if (want && rec.kind == HLT) begin
            state      <= DRAIN;
            hlt_queued <= push;
          end
        end
        // A dropped HLT never pops, so fall back to waiting for empty.
        DRAIN: begin
          if ((hlt_queued && pop && head.kind == HLT) || (!hlt_queued && empty))
            state <= DONE;
        end
        default: state <= DONE;
      endcase
    end
  end

  assign drained    = (state == DONE);
  assign stall_req  = (CW'(DEPTH) - count) <= CW'(STALL_MARGIN);
  assign trace_seq  = trace_valid ? head.seq  : 16'd0;
  assign trace_kind = trace_valid ? head.kind : 2'd0;
  assign trace_pc   = trace_valid ? head.pc   : 16'd0;
  assign trace_addr = trace_valid ? head.addr : 16'd0;
  assign trace_data = trace_valid ? head.data : 16'd0;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed self-checking bench for commit_trace_unit (DEPTH=8, STALL_MARGIN=2).
module tb_commit_trace_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ret_valid;
  logic [15:0] ret_pc;
  logic        ret_regwrite;
  logic [3:0]  ret_rd;
  logic [15:0] ret_wdata;
  logic        ret_memwrite;
  logic [15:0] ret_maddr;
  logic [15:0] ret_mdata;
  logic        ret_hlt;
  logic        stall_req;
  logic        trace_valid;
  logic        trace_ready;
  logic [15:0] trace_seq;
  logic [1:0]  trace_kind;
  logic [15:0] trace_pc;
  logic [15:0] trace_addr;
  logic [15:0] trace_data;
  logic        overflow;
  logic        drained;

  int n_checks = 0;
  int n_errors = 0;

  // Expected records, packed {seq, kind, pc, addr, data}.
  logic [65:0] exp_q[$];

  always #5 clk = ~clk;

  commit_trace_unit #(.DEPTH(8), .STALL_MARGIN(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ret_valid    (ret_valid),
    .ret_pc       (ret_pc),
    .ret_regwrite (ret_regwrite),
    .ret_rd       (ret_rd),
    .ret_wdata    (ret_wdata),
    .ret_memwrite (ret_memwrite),
    .ret_maddr    (ret_maddr),
    .ret_mdata    (ret_mdata),
    .ret_hlt      (ret_hlt),
    .stall_req    (stall_req),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_seq    (trace_seq),
    .trace_kind   (trace_kind),
    .trace_pc     (trace_pc),
    .trace_addr   (trace_addr),
    .trace_data   (trace_data),
    .overflow     (overflow),
    .drained      (drained)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ret_valid    = 1'b0;
    ret_pc       = 16'd0;
    ret_regwrite = 1'b0;
    ret_rd       = 4'd0;
    ret_wdata    = 16'd0;
    ret_memwrite = 1'b0;
    ret_maddr    = 16'd0;
    ret_mdata    = 16'd0;
    ret_hlt      = 1'b0;
  endtask

  task automatic drive_ret(input logic [15:0] pc, input logic rw, input logic [3:0] rd,
                           input logic [15:0] wd, input logic mw, input logic [15:0] ma,
                           input logic [15:0] md, input logic h);
    ret_valid    = 1'b1;
    ret_pc       = pc;
    ret_regwrite = rw;
    ret_rd       = rd;
    ret_wdata    = wd;
    ret_memwrite = mw;
    ret_maddr    = ma;
    ret_mdata    = md;
    ret_hlt      = h;
  endtask

  task automatic ret_reg(input logic [15:0] pc, input logic [3:0] rd, input logic [15:0] wd);
    drive_ret(pc, 1'b1, rd, wd, 1'b0, 16'd0, 16'd0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    trace_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [65:0] e);
    check({tag, ".valid"}, {31'd0, trace_valid}, 32'd1);
    check({tag, ".seq"},   {16'd0, trace_seq},  {16'd0, e[65:50]});
    check({tag, ".kind"},  {30'd0, trace_kind}, {30'd0, e[49:48]});
    check({tag, ".pc"},    {16'd0, trace_pc},   {16'd0, e[47:32]});
    check({tag, ".addr"},  {16'd0, trace_addr}, {16'd0, e[31:16]});
    check({tag, ".data"},  {16'd0, trace_data}, {16'd0, e[15:0]});
  endtask

  // Pops every queued expectation in order with ready held high.
  task automatic drain_expect(input string tag);
    logic [65:0] e;
    trace_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_head(tag, e);
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();
    check("rst.valid",    {31'd0, trace_valid}, 32'd0);
    check("rst.stall",    {31'd0, stall_req},   32'd0);
    check("rst.overflow", {31'd0, overflow},    32'd0);
    check("rst.drained",  {31'd0, drained},     32'd0);
    check("rst.seq",      {16'd0, trace_seq},   32'd0);

    // 1: REG, MEM, RETIRE streaming with ready high, then kind priority.
    trace_ready = 1'b1;
    ret_reg(16'h0002, 4'd3, 16'h00A5);
    step();
    check_head("t1.reg", {16'd0, 2'd1, 16'h0002, 16'h0003, 16'h00A5});
    drive_ret(16'h0004, 1'b0, 4'd0, 16'd0, 1'b1, 16'h0010, 16'h1234, 1'b0);
    step();
    check_head("t1.mem", {16'd1, 2'd2, 16'h0004, 16'h0010, 16'h1234});
    drive_ret(16'h0006, 1'b0, 4'd0, 16'd0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step();
`ifdef TRACE_FILTER_NOP_EN
    check("t1.nop_filtered", {31'd0, trace_valid}, 32'd0);
    drive_ret(16'h0008, 1'b1, 4'd5, 16'h5555, 1'b1, 16'h0020, 16'h7777, 1'b0);
    step();
    check_head("t1.prio_mem", {16'd2, 2'd2, 16'h0008, 16'h0020, 16'h7777});
`else
    check_head("t1.nop", {16'd2, 2'd0, 16'h0006, 16'h0000, 16'h0000});
    drive_ret(16'h0008, 1'b1, 4'd5, 16'h5555, 1'b1, 16'h0020, 16'h7777, 1'b0);
    step();
    check_head("t1.prio_mem", {16'd3, 2'd2, 16'h0008, 16'h0020, 16'h7777});
`endif
    idle();
    step();
    check("t1.empty", {31'd0, trace_valid}, 32'd0);

    // 2: fill with ready low, stall threshold, overflow, ordered drain.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ret_reg(16'(2 * i), 4'(i), 16'(16'h0100 + i));
      step();
      check($sformatf("t2.stall%0d", i + 1), {31'd0, stall_req}, {31'd0, (i + 1) >= 6});
      exp_q.push_back({16'(i), 2'd1, 16'(2 * i), 16'(i), 16'(16'h0100 + i)});
    end
    check("t2.no_ovf_full", {31'd0, overflow}, 32'd0);
    ret_reg(16'h0100, 4'd9, 16'hDEAD);
    step();
    idle();
    check("t2.ovf", {31'd0, overflow}, 32'd1);
    drain_expect("t2.pop");
    check("t2.empty", {31'd0, trace_valid}, 32'd0);
    ret_reg(16'h0200, 4'd1, 16'hBEEF);
    step();
    idle();
    check("t2.seq_after_drop", {16'd0, trace_seq}, 32'd8);
    check("t2.ovf_sticky", {31'd0, overflow}, 32'd1);

    // 3: push coincident with pop while full is accepted.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ret_reg(16'(2 * i), 4'(i), 16'(i));
      step();
    end
    trace_ready = 1'b1;
    ret_reg(16'h0050, 4'd2, 16'h0A0A);
    step();
    idle();
    trace_ready = 1'b0;
    check("t3.ovf", {31'd0, overflow}, 32'd0);
    check("t3.stall_full", {31'd0, stall_req}, 32'd1);
    for (int i = 1; i < 8; i++) exp_q.push_back({16'(i), 2'd1, 16'(2 * i), 16'(i), 16'(i)});
    exp_q.push_back({16'd8, 2'd1, 16'h0050, 16'h0002, 16'h0A0A});
    drain_expect("t3.pop");

    // 4: sequence number wrap.
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < 16'hFFFE; i++) begin
      ret_reg(16'h0001, 4'd1, 16'h0001);
      step();
    end
    idle();
    step();
    check("t4.empty", {31'd0, trace_valid}, 32'd0);
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ret_reg(16'(16'h00A0 + 2 * i), 4'd4, 16'(i));
      step();
    end
    idle();
    exp_q.push_back({16'hFFFE, 2'd1, 16'h00A0, 16'h0004, 16'h0000});
    exp_q.push_back({16'hFFFF, 2'd1, 16'h00A2, 16'h0004, 16'h0001});
    exp_q.push_back({16'h0000, 2'd1, 16'h00A4, 16'h0004, 16'h0002});
    drain_expect("t4.wrap");

    // 5: HLT behind two records, extra retirements ignored, drain to DONE.
    do_reset();
    ret_reg(16'h0010, 4'd1, 16'h0011);
    step();
    ret_reg(16'h0012, 4'd2, 16'h0022);
    step();
    drive_ret(16'h0020, 1'b1, 4'd7, 16'h7777, 1'b1, 16'h0040, 16'h4444, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      ret_reg(16'h0030, 4'd3, 16'h0033);
      step();
    end
    check("t5.ovf", {31'd0, overflow}, 32'd0);
    check("t5.drained_early", {31'd0, drained}, 32'd0);
    trace_ready = 1'b1;
    check_head("t5.r0", {16'd0, 2'd1, 16'h0010, 16'h0001, 16'h0011});
    step();
    check_head("t5.r1", {16'd1, 2'd1, 16'h0012, 16'h0002, 16'h0022});
    step();
    check_head("t5.hlt", {16'd2, 2'd3, 16'h0020, 16'h0000, 16'h0000});
    check("t5.drained_pre", {31'd0, drained}, 32'd0);
    step();
    check("t5.drained", {31'd0, drained}, 32'd1);
    check("t5.valid_done", {31'd0, trace_valid}, 32'd0);
    step();
    step();
    check("t5.valid_done2", {31'd0, trace_valid}, 32'd0);
    check("t5.drained2", {31'd0, drained}, 32'd1);
    idle();

    // 6: reset mid-stream discards pending records.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ret_reg(16'(16'h0060 + i), 4'(i), 16'(i));
      step();
    end
    idle();
    check("t6.pending", {31'd0, trace_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6.valid", {31'd0, trace_valid}, 32'd0);
    check("t6.ovf", {31'd0, overflow}, 32'd0);
    check("t6.drained", {31'd0, drained}, 32'd0);
    ret_reg(16'h0070, 4'd6, 16'h0066);
    step();
    idle();
    check_head("t6.seq0", {16'd0, 2'd1, 16'h0070, 16'h0006, 16'h0066});
    trace_ready = 1'b1;
    drive_ret(16'h0072, 1'b0, 4'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1'b0);
    step();
    idle();
`ifdef TRACE_FILTER_NOP_EN
    check("t6.nop_filtered", {31'd0, trace_valid}, 32'd0);
`else
    check_head("t6.nop", {16'd1, 2'd0, 16'h0072, 16'h0000, 16'h0000});
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
